// File: rtl/sdm_access_scheduler.sv
// sdm_access_scheduler
//   Arbitrates trainer writes and query reads onto a single SDM port.
//   When both are pending it alternates between them (round robin).
//   A read waits up to TIMEOUT cycles for the SDM response and is then
//   aborted with rd_timeout set.
//
// Ports
//   clk, rstb                      clock; synchronous active-high reset
//   wr_req/wr_addr -> wr_ack       write request, held until its ack pulse
//   rd_req/rd_addr -> rd_ack       read request, held until its ack pulse
//   rd_done/rd_success/rd_timeout/rd_data
//                                  read result, valid while rd_done=1
//   train_en                       gates write grants
//   sdm_valid/sdm_wnr/sdm_address  command to the SDM
//   sdm_read_valid/sdm_read_success/sdm_data
//                                  read response from the SDM
//   busy                           high whenever the FSM is not in IDLE
//   wr_count                       saturating count of issued writes
module sdm_access_scheduler #(
   parameter int BIT_WIDTH     = 8,
   parameter int TIMEOUT       = 15,
   parameter int TO_WIDTH      = 4,
   parameter int COUNTER_WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     rstb,
   input  logic                     wr_req,
   input  logic [BIT_WIDTH-1:0]     wr_addr,
   output logic                     wr_ack,
   input  logic                     rd_req,
   input  logic [BIT_WIDTH-1:0]     rd_addr,
   output logic                     rd_ack,
   output logic                     rd_done,
   output logic                     rd_success,
   output logic                     rd_timeout,
   output logic [BIT_WIDTH-1:0]     rd_data,
   input  logic                     train_en,
   output logic                     sdm_valid,
   output logic                     sdm_wnr,
   output logic [BIT_WIDTH-1:0]     sdm_address,
   input  logic                     sdm_read_valid,
   input  logic                     sdm_read_success,
   input  logic [BIT_WIDTH-1:0]     sdm_data,
   output logic                     busy,
   output logic [COUNTER_WIDTH-1:0] wr_count
);

   typedef enum logic [2:0] {IDLE, WRITE, READ_ISSUE, READ_WAIT, RESP} state_t;

   // Counter value during the last permitted READ_WAIT cycle.
   localparam logic [TO_WIDTH-1:0]      TO_LAST = TO_WIDTH'(TIMEOUT - 1);
   localparam logic [COUNTER_WIDTH-1:0] WC_MAX  = '1;

   state_t              state;
   logic                last_wr;   // 1: last grant was a write
   logic [TO_WIDTH-1:0] to_cnt;
   logic                wr_cand;
   logic                rd_pick;

   assign wr_cand = wr_req & train_en;
   // Read wins when it is the only candidate, or under contention when
   // the previous grant went to the writer.
   assign rd_pick = rd_req & (~wr_cand | last_wr);

   always_ff @(posedge clk) begin
      if (rstb) begin
         state       <= IDLE;
         last_wr     <= 1'b1;
         to_cnt      <= '0;
         wr_count    <= '0;
         wr_ack      <= 1'b0;
         rd_ack      <= 1'b0;
         rd_done     <= 1'b0;
         rd_success  <= 1'b0;
         rd_timeout  <= 1'b0;
         rd_data     <= '0;
         sdm_valid   <= 1'b0;
         sdm_wnr     <= 1'b0;
         sdm_address <= '0;
         busy        <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (rd_pick) begin
                  state       <= READ_ISSUE;
                  last_wr     <= 1'b0;
                  sdm_valid   <= 1'b1;
                  sdm_wnr     <= 1'b0;
                  sdm_address <= rd_addr;
                  rd_ack      <= 1'b1;
                  busy        <= 1'b1;
               end else if (wr_cand) begin
                  state       <= WRITE;
                  last_wr     <= 1'b1;
                  sdm_valid   <= 1'b1;
                  sdm_wnr     <= 1'b1;
                  sdm_address <= wr_addr;
                  wr_ack      <= 1'b1;
                  busy        <= 1'b1;
               end
            end
            WRITE: begin
               // The write is committed once here; train_en no longer matters.
               state     <= IDLE;
               sdm_valid <= 1'b0;
               sdm_wnr   <= 1'b0;
               wr_ack    <= 1'b0;
               busy      <= 1'b0;
               if (wr_count != WC_MAX) wr_count <= wr_count + 1'b1;
            end
            READ_ISSUE: begin
               state     <= READ_WAIT;
               sdm_valid <= 1'b0;
               rd_ack    <= 1'b0;
               to_cnt    <= '0;
            end
            READ_WAIT: begin
               to_cnt <= to_cnt + 1'b1;
               // A response in the final cycle still beats the timeout.
               if (sdm_read_valid) begin
                  state      <= RESP;
                  rd_done    <= 1'b1;
                  rd_success <= sdm_read_success;
                  rd_timeout <= 1'b0;
                  rd_data    <= sdm_data;
               end else if (to_cnt == TO_LAST) begin
                  state      <= RESP;
                  rd_done    <= 1'b1;
                  rd_success <= 1'b0;
                  rd_timeout <= 1'b1;
                  rd_data    <= '0;
               end
            end
            RESP: begin
               state      <= IDLE;
               rd_done    <= 1'b0;
               rd_success <= 1'b0;
               rd_timeout <= 1'b0;
               rd_data    <= '0;
               busy       <= 1'b0;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/sdm_access_scheduler.md
SDM_ACCESS_SCHEDULER -- requirements
Module: sdm_access_scheduler

Interface
REQ-001 Parameter BIT_WIDTH, default 8, SDM address/data width.
REQ-002 Parameter TIMEOUT, default 15, maximum READ_WAIT cycles before read abort (1..2^TO_WIDTH-1).
REQ-003 Parameter TO_WIDTH, default 4, width of the timeout counter.
REQ-004 Parameter COUNTER_WIDTH, default 8, width of the write counter.
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 rstb  in  1  reset, synchronous, active-high (1 = reset).
REQ-007 wr_req, wr_addr  in  1, BIT_WIDTH  trainer write request and address; held until wr_ack.
REQ-008 wr_ack  out  1  one-cycle pulse: write accepted and issued.
REQ-009 rd_req, rd_addr  in  1, BIT_WIDTH  query request and address; held until rd_ack.
REQ-010 rd_ack  out  1  one-cycle pulse: read issued to SDM.
REQ-011 rd_done, rd_success, rd_timeout, rd_data  out  1, 1, 1, BIT_WIDTH  read result; all valid only while rd_done=1.
REQ-012 train_en  in  1  when 0, write requests are not granted.
REQ-013 sdm_valid, sdm_wnr, sdm_address  out  1, 1, BIT_WIDTH  to SDM valid/wnr/address.
REQ-014 sdm_read_valid, sdm_read_success, sdm_data  in  1, 1, BIT_WIDTH  from SDM readValid/readSuccess/data.
REQ-015 busy  out  1  high in any state other than IDLE.
REQ-016 wr_count  out  COUNTER_WIDTH  number of writes issued since reset, saturating.

Function
REQ-017 FSM states IDLE, WRITE, READ_ISSUE, READ_WAIT, RESP; all outputs registered.
REQ-018 IDLE: candidates are rd_req and (wr_req & train_en); none -> stay IDLE.
REQ-019 One candidate -> grant it; both -> grant opposite of last_grant (round robin), last_grant reset value = write (so first contention grants read).
REQ-020 Write grant -> WRITE for exactly one cycle: sdm_valid=1, sdm_wnr=1, sdm_address=wr_addr sampled in IDLE, wr_ack=1; then IDLE.
REQ-021 Read grant -> READ_ISSUE for exactly one cycle: sdm_valid=1, sdm_wnr=0, sdm_address=rd_addr sampled in IDLE, rd_ack=1; then READ_WAIT.
REQ-022 sdm_valid=0 and sdm_wnr=0 in every state except WRITE and READ_ISSUE; sdm_address holds last issued value.
REQ-023 sdm_read_valid is ignored outside READ_WAIT.
REQ-024 READ_WAIT: timeout counter cleared on entry and incremented each cycle; sdm_read_valid=1 -> capture sdm_read_success and sdm_data, go RESP.
REQ-025 READ_WAIT: counter reaches TIMEOUT with sdm_read_valid=0 -> RESP with rd_success=0, rd_timeout=1, rd_data=0; sdm_read_valid in that same cycle takes priority over timeout.
REQ-026 RESP: rd_done=1 for exactly one cycle with captured values, then IDLE; rd_success, rd_timeout, rd_data return to 0 when rd_done=0.
REQ-027 Minimum op spacing: write 2 cycles (IDLE+WRITE); read 4 cycles with 1-cycle SDM latency.
REQ-028 wr_count increments by 1 in each WRITE cycle; at 2^COUNTER_WIDTH-1 it holds.
REQ-029 train_en deasserted during WRITE does not cancel that write; it blocks only later grants.
REQ-030 Requests dropped before ack are not remembered; requests arriving outside IDLE wait until IDLE.

Reset
REQ-031 rstb=1 at a clock edge -> state IDLE, last_grant=write, timeout counter 0, wr_count 0, all outputs 0 (including sdm_address) on the next cycle, regardless of state.
REQ-032 Reset mid-read discards the outstanding read: no rd_done is produced; a late sdm_read_valid after reset is ignored.

Verification
REQ-033 Single write: train_en=1, wr_req=1, wr_addr=0xF0 -> next cycle sdm_valid=1, sdm_wnr=1, sdm_address=0xF0, wr_ack=1; wr_count=1 thereafter.
REQ-034 Read hit: rd_addr=0xAA, SDM returns read_valid 2 cycles after issue with success=1, data=0xFF -> rd_ack pulse, then rd_done=1, rd_success=1, rd_data=0xFF, rd_timeout=0.
REQ-035 Timeout: read issued, sdm_read_valid held 0 -> rd_done=1 with rd_timeout=1, rd_success=0, rd_data=0 exactly TIMEOUT cycles after entering READ_WAIT.
REQ-036 Contention: wr_req and rd_req held continuously -> grants alternate read, write, read, write; neither starves; train_en=0 -> only reads granted.
REQ-037 Saturation: 300 writes with COUNTER_WIDTH=8 -> wr_count ends at 0xFF.
REQ-038 Reset in READ_WAIT, then sdm_read_valid=1 -> no rd_done, all outputs 0, busy=0.
